// File: rtl/quant_pkg.sv
// Shared constants, types, FSM encoding and int8 saturation helper for quant_router_int8.
package quant_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned BEATS     = 4;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned SCALE_W   = 16;
    localparam int unsigned PROD_W    = 49;
    localparam int unsigned SHIFT_MAX = 47;
    localparam int unsigned CNT_W     = $clog2(BEATS + 1);
    localparam int unsigned IDX_W     = $clog2(BEATS);

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [7:0]        q8_t;
    // Headroom for the rounding constant and zero-point add on top of the product
    typedef logic signed [PROD_W+1:0] wide_t;

    typedef enum logic [0:0] {FILL, HOLD} state_t;

    function automatic q8_t sat8(input wide_t v);
        if (v > 127) begin
            return 8'sd127;
        end else if (v < -128) begin
            return -8'sd128;
        end else begin
            return q8_t'(v[7:0]);
        end
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of requantization: registered multiply, then rounding shift, zero-point add and
// int8 saturation. Optional fused ReLU clamp when QUANT_RELU_EN is defined.
module requant_lane
    import quant_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [ACC_W-1:0]   in_data,
    input  logic [SCALE_W-1:0] scale,
    input  logic [5:0]         shift,
    input  logic [7:0]         zp,
    output logic [7:0]         q
);

    prod_t prod_d, prod_q;
    prod_t op_a, op_b;
    wide_t rounded, summed;
    q8_t   sat;

    always_comb begin
        op_a   = prod_t'({{(PROD_W-ACC_W){in_data[ACC_W-1]}}, in_data});
        op_b   = prod_t'({{(PROD_W-SCALE_W){1'b0}}, scale});
        prod_d = op_a * op_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
        end else if (load) begin
            prod_q <= prod_d;
        end
    end

    always_comb begin
        if (shift == 6'd0) begin
            rounded = wide_t'(prod_q);
        end else begin
            // Round half up, then arithmetic shift (floor) gives round-to-nearest, ties up
            rounded = (wide_t'(prod_q) + (wide_t'(1) << (shift - 6'd1))) >>> shift;
        end
        summed = rounded + wide_t'($signed(zp));
        sat    = sat8(summed);
`ifdef QUANT_RELU_EN
        if (sat < $signed(zp)) begin
            sat = $signed(zp);
        end
`endif
        q = sat;
    end

endmodule

// File: rtl/quant_router_int8.sv
// Requantizes 4-lane int32 accumulator beats to int8 and packs 4 beats into a 16-byte packet
// with valid/ready handoff. Define QUANT_RELU_EN to clamp results below the zero point.
module quant_router_int8
    import quant_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ACC_W*LANES-1:0]   in_data,
    input  logic [SCALE_W-1:0]       cfg_scale,
    input  logic [5:0]               cfg_shift,
    input  logic [7:0]               cfg_zp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*LANES*BEATS-1:0] out_data,
    output logic [15:0]              pkt_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_cnt_q, wr_cnt_q;
    logic               s1_valid_q, out_valid_q;
    logic [15:0]        pkt_count_q;
    logic [SCALE_W-1:0] scale_q, lane_scale;
    logic [5:0]         shift_q, shift_clamped;
    logic [7:0]         zp_q;
    logic [7:0]         pkt_q [BEATS][LANES];
    logic [7:0]         lane_q [LANES];
    logic               accept, first_beat, handoff;

    assign in_ready   = reset && (state_q == FILL) && (acc_cnt_q < CNT_W'(BEATS));
    assign accept     = in_valid && in_ready;
    assign first_beat = accept && (acc_cnt_q == '0);
    assign handoff    = out_valid_q && out_ready;
    // The first beat multiplies with the live scale, as the shadow is only loaded at that edge
    assign lane_scale    = (acc_cnt_q == '0) ? cfg_scale : scale_q;
    assign shift_clamped = (cfg_shift > 6'(SHIFT_MAX)) ? 6'(SHIFT_MAX) : cfg_shift;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (s1_valid_q && wr_cnt_q == CNT_W'(BEATS - 1)) state_d = HOLD;
            HOLD: if (handoff) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            acc_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pkt_count_q <= '0;
            scale_q     <= '0;
            shift_q     <= '0;
            zp_q        <= '0;
            for (int b = 0; b < BEATS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    pkt_q[b][l] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            if (first_beat) begin
                scale_q <= cfg_scale;
                shift_q <= shift_clamped;
                zp_q    <= cfg_zp;
            end
            if (handoff) begin
                acc_cnt_q   <= '0;
                wr_cnt_q    <= '0;
                out_valid_q <= 1'b0;
                pkt_count_q <= pkt_count_q + 16'd1;
            end else begin
                if (accept) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                if (s1_valid_q) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                if (state_q == HOLD) out_valid_q <= 1'b1;
            end
            if (s1_valid_q) begin
                for (int l = 0; l < LANES; l++) begin
                    pkt_q[wr_cnt_q[IDX_W-1:0]][l] <= lane_q[l];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        requant_lane u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (accept),
            .in_data (in_data[l*ACC_W +: ACC_W]),
            .scale   (lane_scale),
            .shift   (first_beat ? shift_clamped : shift_q),
            .zp      (first_beat ? cfg_zp : zp_q),
            .q       (lane_q[l])
        );
    end

    for (genvar b = 0; b < BEATS; b++) begin : g_out_beat
        for (genvar l = 0; l < LANES; l++) begin : g_out_lane
            assign out_data[(b*LANES+l)*8 +: 8] = pkt_q[b][l];
        end
    end

    assign out_valid = out_valid_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_quant_router_int8.sv
// Scoreboard bench for quant_router_int8: driver feeds a behavioural model that queues expected
// packets; a monitor pops and compares on every handoff.
module tb_quant_router_int8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [15:0]  cfg_scale;
    logic [5:0]   cfg_shift;
    logic [7:0]   cfg_zp;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [15:0]  pkt_count;

    int n_checks = 0;
    int n_pass = 0;
    int rdy_mode = 1;           // 0: hold low, 1: hold high, 2: random
    int mon_cnt = 0;
    logic [127:0] exp_q[$];

    int           m_beat = 0;
    longint       m_scale;
    int           m_shift;
    int           m_zp;
    logic [127:0] m_pkt;

    quant_router_int8 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_scale (cfg_scale),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_q(input longint acc, input longint scale, input int shift,
                                         input int zp);
        longint p, r;
        int s;
        s = (shift > 47) ? 47 : shift;
        p = acc * scale;
        if (s == 0) r = p;
        else r = (p + (longint'(1) << (s - 1))) >>> s;
        r = r + zp;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`ifdef QUANT_RELU_EN
        if (r < zp) r = zp;
`endif
        return 8'(r);
    endfunction

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic model_accept(input logic [127:0] data);
        if (m_beat == 0) begin
            m_scale = longint'(cfg_scale);
            m_shift = int'(cfg_shift);
            m_zp    = int'($signed(cfg_zp));
        end
        for (int l = 0; l < 4; l++) begin
            m_pkt[(m_beat*4+l)*8 +: 8] =
                ref_q(longint'($signed(data[32*l +: 32])), m_scale, m_shift, m_zp);
        end
        m_beat++;
        if (m_beat == 4) begin
            exp_q.push_back(m_pkt);
            m_beat = 0;
        end
    endtask

    task automatic send_beat(input logic [127:0] data);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 128'(in_ready), 128'(1));
        end else begin
            model_accept(data);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [127:0] d0, input logic [127:0] d1,
                               input logic [127:0] d2, input logic [127:0] d3);
        send_beat(d0);
        send_beat(d1);
        send_beat(d2);
        send_beat(d3);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", 128'(out_valid), 128'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b0;
            else if (rdy_mode == 1) out_ready = 1'b1;
            else out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops on every handoff and checks that a stalled packet holds its data
    initial begin
        logic         stall = 1'b0;
        logic [127:0] held = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall = 1'b0;
            end else begin
                if (stall && out_valid) check("hold_stable", out_data, held);
                if (out_valid && out_ready) begin
                    check("pkt_count", 128'(pkt_count), 128'(mon_cnt[15:0]));
                    if (exp_q.size() == 0) begin
                        check("unexpected_packet", out_data, 128'hx);
                    end else begin
                        check("packet", out_data, exp_q.pop_front());
                    end
                    mon_cnt++;
                    stall = 1'b0;
                end else if (out_valid) begin
                    stall = 1'b1;
                    held  = out_data;
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_scale = 16'd32768;
        cfg_shift = 6'd16;
        cfg_zp    = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_pkt_count", 128'(pkt_count), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        reset = 1'b1;

        // Basic scale with latency and counter checks
        send_packet(pack4(100, 100, 100, 100), pack4(100, 100, 100, 100),
                    pack4(100, 100, 100, 100), pack4(100, 100, 100, 100));
        @(posedge clk); #1;
        check("latency_early", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        check("latency_valid", 128'(out_valid), 128'(1));
        check("basic_value", out_data, {16{8'd50}});
        @(posedge clk); #1;
        check("pkt_count_one", 128'(pkt_count), 128'(1));
        wait_drain();

        // Rounding and sign
        send_packet(pack4(3, -3, 5, -5), pack4(3, -3, 5, -5), pack4(-5, 5, -3, 3), pack4(0, 1, -1, 2));
        wait_drain();

        // Saturation and zero point
        cfg_scale = 16'd1; cfg_shift = 6'd0; cfg_zp = 8'hfe;
        send_packet(pack4(1000, -1000, 0, 254), pack4(1000, -1000, 0, 254),
                    pack4(-130, 129, -126, 125), pack4(1000, -1000, 0, 254));
        wait_drain();

        // Backpressure: stalled packet, in_valid ignored while in_ready is low
        rdy_mode = 0;
        cfg_scale = 16'd32768; cfg_shift = 6'd16; cfg_zp = 8'd3;
        send_packet(pack4(7, 8, 9, 10), pack4(-7, -8, -9, -10), pack4(200, 300, 400, 500),
                    pack4(1, 2, 3, 4));
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pack4(9999, -9999, 12345, -12345);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 1;
        begin
            int n = 0;
            while (!(out_valid && out_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("bp_ready_before", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check("bp_ready_after", 128'(in_ready), 128'(1));
        wait_drain();

        // Config latched at first beat
        cfg_scale = 16'd32768; cfg_shift = 6'd16; cfg_zp = 8'd0;
        send_beat(pack4(100, 101, 102, 103));
        cfg_scale = 16'd16384;
        send_beat(pack4(100, 101, 102, 103));
        send_beat(pack4(-100, -101, -102, -103));
        send_beat(pack4(60, 61, 62, 63));
        send_packet(pack4(100, 101, 102, 103), pack4(100, 101, 102, 103),
                    pack4(-100, -101, -102, -103), pack4(60, 61, 62, 63));
        wait_drain();

        // Randomized traffic with random backpressure and shift clamp coverage
        rdy_mode = 2;
        for (int p = 0; p < 20; p++) begin
            cfg_scale = 16'($urandom_range(0, 65535));
            cfg_shift = 6'($urandom_range(0, 63));
            cfg_zp    = 8'($urandom_range(0, 255));
            for (int b = 0; b < 4; b++) begin
                logic [127:0] d;
                for (int l = 0; l < 4; l++) begin
                    d[32*l +: 32] = 32'($signed($urandom) >>> $urandom_range(0, 31));
                end
                send_beat(d);
                cfg_scale = 16'($urandom_range(0, 65535));
            end
        end
        wait_drain();
        rdy_mode = 1;

        // Reset mid-packet discards partial data
        cfg_scale = 16'd32768; cfg_shift = 6'd16; cfg_zp = 8'd0;
        send_beat(pack4(500, 500, 500, 500));
        send_beat(pack4(600, 600, 600, 600));
        @(negedge clk);
        reset  = 1'b0;
        m_beat = 0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_pkt_count", 128'(pkt_count), 128'(0));
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        mon_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        send_packet(pack4(2, 4, 6, 8), pack4(-2, -4, -6, -8), pack4(10, 12, 14, 16),
                    pack4(20, 22, 24, 26));
        wait_drain();
        check("pkt_count_after_rst", 128'(pkt_count), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/quant_router_int8.md
Name: quant_router_int8

Overview:
- Downstream stage of the int8 systolic core; consumes the 4-lane, 32-bit signed accumulator results the core emits each cycle.
- Requantizes each lane to int8 (scale multiply, rounding shift, zero-point add, saturate) in a 2-stage pipeline.
- Packs 4 beats into a 16-element int8 packet and presents it to the next layer/router with a valid/ready handshake.

Parameters:
- LANES, 4, results per input beat (array width)
- BEATS, 4, input beats per output packet
- ACC_W, 32, accumulator width (signed)
- SCALE_W, 16, requant multiplier width (unsigned)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset; low asserts, deassertion is synchronous to clk
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  ACC_W x LANES  signed accumulator results, lane 0 first
- cfg_scale  in  SCALE_W  unsigned multiplier
- cfg_shift  in  6  right-shift amount, 0..47
- cfg_zp  in  8  signed zero point
- out_valid  out  1  packet valid
- out_ready  in  1  consumer accepts packet
- out_data  out  8 x (LANES*BEATS)  signed int8 packet, element i = beat i/LANES, lane i%LANES
- pkt_count  out  16  packets delivered, wraps at 65535->0

Behaviour:
- Reset (reset low): in_ready=0 during reset, out_valid=0, out_data=all 0, pkt_count=0, pipeline valids cleared, counters 0, state FILL. Reset mid-packet discards all partial data.
- States: FILL (accepting beats), HOLD (packet complete, awaiting out_ready).
- in_ready = (state==FILL) && (acc_cnt < BEATS). acc_cnt counts accepted beats (in_valid && in_ready) in the current packet.
- cfg_* sampled into shadow registers on the first accepted beat of a packet (acc_cnt==0); held constant for the packet. cfg_shift > 47 treated as 47.
- Stage 1 (cycle after accept): prod = signed(in_data) * unsigned(cfg_scale), 49-bit signed, per lane.
- Stage 2: if shift>0, r = (prod + (1 << (shift-1))) >>> shift (round half up, arithmetic shift); if shift==0, r = prod. q = r + cfg_zp; saturate q to [-128, 127]. Result written into packet slot wr_cnt; wr_cnt increments.
- Latency: accepted beat lands in packet register 2 cycles after acceptance. Full throughput: 1 beat/cycle in FILL.
- FILL -> HOLD when wr_cnt reaches BEATS (last write cycle); out_valid=1 the following cycle, out_data stable while out_valid && !out_ready.
- HOLD: on out_valid && out_ready: out_valid=0, acc_cnt=wr_cnt=0, pkt_count+1, state FILL; in_ready rises the next cycle (no same-cycle accept).
- in_valid while in_ready=0 is ignored (not an error); in_data unstored.
- out_data retains last packet after handoff until overwritten.

Optional Feature:
- QUANT_RELU_EN: when defined, after zero-point add and saturation, values below cfg_zp are clamped to cfg_zp (fused ReLU in quantized domain). When undefined, no clamp; full [-128,127] range.

Decomposition:
- Package quant_pkg: LANES, BEATS, ACC_W, SCALE_W constants; typedefs acc_t (signed ACC_W), prod_t (signed 49), q8_t (signed 8); state enum {FILL, HOLD}; saturation function sat8.
- Sub-module requant_lane: one lane's 2-stage multiply/round/zp/saturate pipeline, instantiated LANES times; top holds counters, FSM, packet register.

Test Plan:
- Basic scale: scale=32768, shift=16, zp=0, all lanes 100 for 4 beats -> packet all 50, out_valid 3 cycles after 4th accept window, pkt_count=1.
- Rounding/sign: inputs {3,-3,5,-5}, scale=32768, shift=16, zp=0 -> {2,-1,3,-2}.
- Saturation/zp: inputs {1000,-1000,0,254}, scale=1, shift=0, zp=-2 -> {127,-128,-2,127}; with QUANT_RELU_EN, -128 becomes -2.
- Backpressure: out_ready=0 for 10 cycles after packet -> out_data stable, in_ready=0, in_valid beats ignored; out_ready=1 -> handoff, in_ready=1 next cycle.
- Cfg latch: change cfg_scale from 32768 to 16384 after beat 0 of a packet -> entire packet uses 32768; next packet uses 16384.
- Reset mid-packet: assert reset after 2 beats -> out_valid=0, pkt_count=0; 4 fresh beats after release produce packet with only new data.
